sync_fifo_ctrl: RTL and testbench

Parametrised single-clock FIFO that wraps a registered-read dual-port RAM with pointer, level and flag logic.
Buffers ultrasonic ADC sample bursts between the acquisition front end and the USB/readout path.
Generalises the plain dual-port RAM with the following additions:
- write/read handshakes
- full/empty and programmable almost-full/almost-empty flags
- occupancy count
- one-cycle registered read data

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_mem.sv | 29 ++
 rtl/sync_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default flag margins for the sync FIFO slice.
package fifo_pkg;

    localparam int AF_MARGIN  = 2;
    localparam int AE_DEFAULT = 2;

    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    function automatic int cnt_width(input int asize);
        return asize + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write port, registered read address.
module fifo_mem #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 8
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic             i_re,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    logic [DSIZE-1:0] mem_q [1<<ASIZE];
    logic [ASIZE-1:0] raddr_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            raddr_q <= i_raddr;
        end
    end

    assign o_rdata = mem_q[raddr_q];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count, registered flags.
// Optional sticky overflow/underflow flags are enabled by FIFO_ERR_FLAGS_EN.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ASIZE    = 4,
    parameter int DSIZE    = 8,
    parameter int AF_LEVEL = fifo_depth(ASIZE) - AF_MARGIN,
    parameter int AE_LEVEL = AE_DEFAULT
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr,
    input  logic [DSIZE-1:0]            i_data,
    input  logic                        i_rd,
    output logic [DSIZE-1:0]            o_data,
    output logic                        o_rd_valid,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_almost_full,
    output logic                        o_almost_empty,
    output logic [cnt_width(ASIZE)-1:0] o_count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic                        i_err_clr,
    output logic                        o_overflow,
    output logic                        o_underflow
`endif
);

    localparam int CW = cnt_width(ASIZE);
    localparam logic [CW-1:0]    DEPTH_C = CW'(fifo_depth(ASIZE));
    localparam logic [CW-1:0]    AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]    AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [ASIZE-1:0] PTR_ONE = ASIZE'(1);

    logic [ASIZE-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, full_q, af_q, ae_q, rd_valid_q;
    logic [DSIZE-1:0] data_hold_q, mem_rdata;
    logic             wr_acc, rd_acc;

    // Acceptance uses this cycle's registered flags only, so a simultaneous
    // read never frees a slot for a write into a full FIFO and vice versa.
    assign wr_acc = i_wr & ~full_q;
    assign rd_acc = i_rd & ~empty_q;

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            rd_valid_q  <= 1'b0;
            data_hold_q <= '0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == DEPTH_C);
            af_q       <= (count_d >= AF_C);
            ae_q       <= (count_d <= AE_C);
            rd_valid_q <= rd_acc;
            // Latch the delivered word so o_data stays put even if its slot is rewritten.
            if (rd_valid_q) data_hold_q <= mem_rdata;
        end
    end

    fifo_mem #(
        .ASIZE (ASIZE),
        .DSIZE (DSIZE)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_acc),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_data),
        .i_re    (rd_acc),
        .i_raddr (rd_ptr_q),
        .o_rdata (mem_rdata)
    );

    assign o_data         = rd_valid_q ? mem_rdata : data_hold_q;
    assign o_rd_valid     = rd_valid_q;
    assign o_full         = full_q;
    assign o_empty        = empty_q;
    assign o_almost_full  = af_q;
    assign o_almost_empty = ae_q;
    assign o_count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    // A set event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (i_wr && full_q)      ovf_q <= 1'b1;
            else if (i_err_clr)      ovf_q <= 1'b0;
            if (i_rd && empty_q)     udf_q <= 1'b1;
            else if (i_err_clr)      udf_q <= 1'b0;
        end
    end

    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised and directed checks of sync_fifo_ctrl against a queue-based model.
module tb_sync_fifo_ctrl;

    localparam int ASIZE = 3;
    localparam int DSIZE = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr, rd;
    logic [DSIZE-1:0] din;
    logic [DSIZE-1:0] dout;
    logic             rd_valid, full, empty, afull, aempty;
    logic [ASIZE:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
    logic             err_clr;
    logic             ovf, udf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents as a queue plus the expected read-side state.
    logic [DSIZE-1:0] mq[$];
    logic [DSIZE-1:0] exp_data;
    logic             exp_valid;
    logic             exp_ovf, exp_udf;

    sync_fifo_ctrl #(
        .ASIZE    (ASIZE),
        .DSIZE    (DSIZE),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wr           (wr),
        .i_data         (din),
        .i_rd           (rd),
        .o_data         (dout),
        .o_rd_valid     (rd_valid),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (afull),
        .o_almost_empty (aempty),
        .o_count        (count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .i_err_clr      (err_clr),
        .o_overflow     (ovf),
        .o_underflow    (udf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        check("count",    32'(count),  32'(n));
        check("empty",    32'(empty),  32'(n == 0));
        check("full",     32'(full),   32'(n == DEPTH));
        check("afull",    32'(afull),  32'(n >= AF));
        check("aempty",   32'(aempty), 32'(n <= AE));
        check("rd_valid", 32'(rd_valid), 32'(exp_valid));
        check("data",     32'(dout),   32'(exp_data));
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow",  32'(ovf), 32'(exp_ovf));
        check("underflow", 32'(udf), 32'(exp_udf));
`endif
    endtask

    // One clock: drive request, let the model apply the acceptance rules, check.
    task automatic step(input logic w, input logic [DSIZE-1:0] d, input logic r, input logic clr);
        bit was_full, was_empty;
        wr  = w;
        din = d;
        rd  = r;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = clr;
`endif
        @(posedge clk);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        exp_valid = 1'b0;
        if (r && !was_empty) begin
            exp_data  = mq.pop_front();
            exp_valid = 1'b1;
        end
        if (w && !was_full) mq.push_back(d);
        if (w && was_full)   exp_ovf = 1'b1;
        else if (clr)        exp_ovf = 1'b0;
        if (r && was_empty)  exp_udf = 1'b1;
        else if (clr)        exp_udf = 1'b0;
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        check_all();
    endtask

    task automatic model_reset();
        mq.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        din   = '0;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // Three writes then three reads.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Fill, overfill attempt, drain.
        for (int i = 0; i < 8; i++) step(1, 8'(i), 0, 0);
        step(1, 8'hFF, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);

        // Full with simultaneous read and write: only the read goes through.
        for (int i = 0; i < 8; i++) step(1, 8'(8'h80 + i), 0, 0);
        step(1, 8'h99, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 8'h00, 1, 0);

        // Empty with simultaneous read and write: only the write goes through.
        step(1, 8'hAA, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);

        // Steady level 4 with wrapping pointers.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 20; i++) step(1, 8'(8'h44 + i), 1, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0);
        step(0, 8'h00, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_empty", 32'(empty),    32'd1);
        check("rst_count", 32'(count),    32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data",  32'(dout),     32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);
        step(0, 8'h00, 0, 1);

        // Random traffic with varying read/write bias.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step(($urandom_range(0, 9) < 3 + 2 * bias) ? 1'b1 : 1'b0,
                 8'($urandom()),
                 ($urandom_range(0, 9) < 7 - 2 * bias) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
